// File: rtl/perf_snapshot_fifo_if.sv
// Bus bundle for perf_snapshot_fifo: counter capture inputs plus the CSR read/pop port.
// The master modport is the producer/CSR side, the slave modport is the snapshot FIFO.
interface perf_snapshot_fifo_if #(
    parameter int COUNTER_WIDTH = 32,
    parameter int DEPTH         = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                     measurement_done;
    logic [COUNTER_WIDTH-1:0] total_cycles_count;
    logic [COUNTER_WIDTH-1:0] active_cycles_count;
    logic [COUNTER_WIDTH-1:0] idle_cycles_count;
    logic [31:0]              dma_bytes_count;
    logic [31:0]              blocks_processed_count;
    logic [31:0]              stall_cycles_count;
    logic                     rd_req;
    logic [2:0]               rd_addr;
    logic                     pop;
    logic [31:0]              rd_data;
    logic                     rd_valid;
    logic                     rd_err;
    logic                     busy;
    logic [CNT_W-1:0]         count;
    logic                     empty;
    logic                     full;
    logic [7:0]               drop_count;

    modport master (
        output measurement_done, total_cycles_count, active_cycles_count, idle_cycles_count,
               dma_bytes_count, blocks_processed_count, stall_cycles_count,
               rd_req, rd_addr, pop,
        input  rd_data, rd_valid, rd_err, busy, count, empty, full, drop_count
    );

    modport slave (
        input  measurement_done, total_cycles_count, active_cycles_count, idle_cycles_count,
               dma_bytes_count, blocks_processed_count, stall_cycles_count,
               rd_req, rd_addr, pop,
        output rd_data, rd_valid, rd_err, busy, count, empty, full, drop_count
    );
endinterface

// File: rtl/perf_snapshot_fifo.sv
// Captures perf-monitor counters on measurement_done, computes utilization with a serial
// restoring divider, and queues 7-word records in a small FIFO drained through a registered read port.
module perf_snapshot_fifo #(
    parameter int COUNTER_WIDTH = 32,
    parameter int DEPTH         = 4
) (
    input  logic                clk,
    input  logic                rst,
    perf_snapshot_fifo_if.slave bus
);
    localparam int NW    = COUNTER_WIDTH + 7;
    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = PW + 1;
    localparam int IW    = $clog2(NW + 1);

    typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_PUSH} state_t;
    typedef logic [6:0][31:0] rec_t;

    state_t                   r_state;
    logic [5:0][31:0]         r_cap;
    logic [NW-1:0]            r_num;
    logic [COUNTER_WIDTH-1:0] r_den;
    logic [NW-1:0]            r_quo;
    logic [COUNTER_WIDTH-1:0] r_rem;
    logic [IW-1:0]            r_iter;
    rec_t                     r_mem [DEPTH];
    logic [PW-1:0]            r_wptr;
    logic [PW-1:0]            r_rptr;
    logic [CNT_W-1:0]         r_count;
    logic [7:0]               r_drop;
    logic [31:0]              r_rd_data;
    logic                     r_rd_valid;
    logic                     r_rd_err;

    logic [NW-1:0]            w_act_ext;
    logic [COUNTER_WIDTH:0]   w_rem_sh;
    logic [COUNTER_WIDTH:0]   w_diff;
    logic                     w_ge;
    logic [COUNTER_WIDTH-1:0] w_rem_nx;
    logic [7:0]               w_util;
    rec_t                     w_rec;
    logic                     w_empty;
    logic                     w_full;
    logic                     w_busy;
    logic                     w_pop;
    logic                     w_push;
    logic [1:0]               w_drop_inc;
    logic [8:0]               w_drop_sum;
    logic [31:0]              w_status;

    // The borrow out of the trial subtraction doubles as the restoring-step compare,
    // since the partial remainder always stays below twice the divisor.
    assign w_act_ext = NW'(bus.active_cycles_count);
    assign w_rem_sh  = {r_rem, r_num[NW-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_den};
    assign w_ge      = ~w_diff[COUNTER_WIDTH];
    assign w_rem_nx  = w_ge ? w_diff[COUNTER_WIDTH-1:0] : w_rem_sh[COUNTER_WIDTH-1:0];

    assign w_util = (r_den == '0)        ? 8'd0   :
                    (r_quo > NW'(100))   ? 8'd100 : r_quo[7:0];
    assign w_rec  = {{24'b0, w_util}, r_cap};

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_busy     = (r_state != S_IDLE);
    assign w_pop      = bus.pop && !w_empty;
    assign w_push     = (r_state == S_PUSH) && (!w_full || w_pop);
    assign w_drop_inc = 2'((bus.measurement_done && w_busy) ? 1 : 0)
                      + 2'(((r_state == S_PUSH) && w_full && !bus.pop) ? 1 : 0);
    assign w_drop_sum = {1'b0, r_drop} + 9'(w_drop_inc);
    assign w_status   = {16'b0, r_drop, 3'b0, w_full, w_empty, w_busy, r_count[1:0]};

    always_ff @(posedge clk) begin
        if (!rst && w_push)
            r_mem[r_wptr] <= w_rec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_drop     <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            r_iter     <= '0;
        end else begin
            // Read port sees the head record as it stands before any same-edge pop/push.
            r_rd_valid <= bus.rd_req;
            r_rd_err   <= bus.rd_req && (bus.rd_addr != 3'd7) && w_empty;
            if (bus.rd_req) begin
                if (bus.rd_addr == 3'd7)
                    r_rd_data <= w_status;
                else if (w_empty)
                    r_rd_data <= '0;
                else
                    r_rd_data <= r_mem[r_rptr][bus.rd_addr];
            end

            r_drop <= (w_drop_sum > 9'd255) ? 8'd255 : w_drop_sum[7:0];

            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (bus.measurement_done) begin
                        r_cap[0] <= 32'(bus.total_cycles_count);
                        r_cap[1] <= 32'(bus.active_cycles_count);
                        r_cap[2] <= 32'(bus.idle_cycles_count);
                        r_cap[3] <= bus.dma_bytes_count;
                        r_cap[4] <= bus.blocks_processed_count;
                        r_cap[5] <= bus.stall_cycles_count;
                        r_num    <= (w_act_ext << 6) + (w_act_ext << 5) + (w_act_ext << 2);
                        r_den    <= bus.total_cycles_count;
                        r_quo    <= '0;
                        r_rem    <= '0;
                        r_iter   <= IW'(NW);
                        r_state  <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    r_rem  <= w_rem_nx;
                    r_quo  <= {r_quo[NW-2:0], w_ge};
                    r_num  <= {r_num[NW-2:0], 1'b0};
                    r_iter <= r_iter - 1'b1;
                    if (r_iter == IW'(1))
                        r_state <= S_PUSH;
                end
                S_PUSH:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_data    = r_rd_data;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_err     = r_rd_err;
    assign bus.busy       = w_busy;
    assign bus.count      = r_count;
    assign bus.empty      = w_empty;
    assign bus.full       = w_full;
    assign bus.drop_count = r_drop;
endmodule
